// File: rtl/debug_view_ctrl.sv
// Debug display source selector: debounced index buttons with auto-repeat, debug read-port
// addressing for the register file and data memory, and a registered display word.
module debug_view_ctrl #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned REG_W         = 5,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DB_CYCLES     = 1000000,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [1:0]        sel,
    input  logic [WIDTH-1:0]  pc_in,
    input  logic [WIDTH-1:0]  status_in,
    output logic [REG_W-1:0]  reg_addr,
    input  logic [WIDTH-1:0]  reg_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_data,
    output logic [WIDTH-1:0]  data_display,
    output logic [7:0]        idx_out
);

    localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
    localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} rpt_state_e;

    // Bit 0 is the increment button, bit 1 the decrement button.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] valid_q;
    logic [1:0] step;

    assign btn_raw = {btn_dec, btn_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            valid_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            valid_q <= {valid_q[0], 1'b1};
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [DB_W-1:0]  db_cnt_q;
        logic             stable_q;
        logic             armed_q;
        logic [TMR_W-1:0] tmr_q, tmr_d;
        logic             step_b;
        rpt_state_e       state_q, state_d;

        // armed_q only sets once a real released level is seen, so a button held through
        // reset cannot produce a step until it is released and pressed again.
        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt_q <= '0;
                stable_q <= 1'b0;
                armed_q  <= 1'b0;
            end else begin
                if (sync2_q[b] == stable_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                    stable_q <= ~stable_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
                if (valid_q[1] && !sync2_q[b] && !stable_q) begin
                    armed_q <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= StIdle;
                tmr_q   <= '0;
            end else begin
                state_q <= state_d;
                tmr_q   <= tmr_d;
            end
        end

        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            step_b  = 1'b0;
            if (!stable_q) begin
                state_d = StIdle;
                tmr_d   = '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (armed_q) begin
                            step_b  = 1'b1;
                            state_d = StHold;
                            tmr_d   = '0;
                        end
                    end
                    StHold: begin
                        if (tmr_q == TMR_W'(HOLD_CYCLES - 1)) begin
                            step_b  = 1'b1;
                            state_d = StRepeat;
                            tmr_d   = '0;
                        end else begin
                            tmr_d = tmr_q + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (tmr_q == TMR_W'(REPEAT_CYCLES - 1)) begin
                            step_b = 1'b1;
                            tmr_d  = '0;
                        end else begin
                            tmr_d = tmr_q + 1'b1;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end

        assign step[b] = step_b;
    end

    logic [REG_W-1:0]  reg_idx_q, reg_idx_d;
    logic [ADDR_W-1:0] mem_idx_q, mem_idx_d;
    logic              move;

    assign move = step[0] ^ step[1];

    always_comb begin
        reg_idx_d = reg_idx_q;
        mem_idx_d = mem_idx_q;
        if (move) begin
            case (sel)
                2'b01:   reg_idx_d = step[0] ? reg_idx_q + 1'b1 : reg_idx_q - 1'b1;
                2'b10:   mem_idx_d = step[0] ? mem_idx_q + 1'b1 : mem_idx_q - 1'b1;
                default: ;
            endcase
        end
    end

    // stale_q covers the cycle where mem_data still belongs to the previous address;
    // entering memory mode is guarded combinationally for the same reason.
    logic       stale_q;
    logic       stale;
    logic [1:0] sel_q;
    logic [WIDTH-1:0] display_d;

    assign stale = stale_q || ((sel == 2'b10) && (sel_q != 2'b10));

    always_comb begin
        display_d = data_display;
        case (sel)
            2'b00:   display_d = pc_in;
            2'b01:   display_d = reg_data;
            2'b10:   if (!stale) display_d = mem_data;
            default: display_d = status_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_idx_q    <= '0;
            mem_idx_q    <= '0;
            stale_q      <= 1'b1;
            sel_q        <= 2'b00;
            data_display <= '0;
        end else begin
            reg_idx_q    <= reg_idx_d;
            mem_idx_q    <= mem_idx_d;
            stale_q      <= (mem_idx_d != mem_idx_q);
            sel_q        <= sel;
            data_display <= display_d;
        end
    end

    assign reg_addr = reg_idx_q;
    assign mem_addr = mem_idx_q;

    always_comb begin
        idx_out = '0;
        case (sel)
            2'b01:   idx_out[REG_W-1:0]  = reg_idx_q;
            2'b10:   idx_out[ADDR_W-1:0] = mem_idx_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Self-checking bench for debug_view_ctrl: expected display words and step timings are
// queued when stimulus is applied and popped when the DUT is sampled on the falling edge.
module tb_debug_view_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_inc, btn_dec;
    logic [1:0]  sel;
    logic [31:0] pc_in, status_in;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic [31:0] data_display;
    logic [7:0]  idx_out;

    logic [31:0] regs [32];
    logic [31:0] mem  [256];

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    assign reg_data = regs[reg_addr];
    always @(posedge clk) mem_data <= mem[mem_addr];

    debug_view_ctrl #(
        .WIDTH(32), .REG_W(5), .ADDR_W(8),
        .DB_CYCLES(4), .HOLD_CYCLES(16), .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .sel(sel),
        .pc_in(pc_in), .status_in(status_in), .reg_addr(reg_addr), .reg_data(reg_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .data_display(data_display),
        .idx_out(idx_out)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the given buttons high for n cycles, then release and let the debouncer settle.
    task automatic press(input logic inc, input logic dec, input int n);
        btn_inc = inc;
        btn_dec = dec;
        tick(n);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        tick(12);
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_inc = 1'b1; btn_dec = 1'b1; sel = 2'b01;
        tick(2);
        sb.push_back('{"reset_display", 32'h0});
        sb.push_back('{"reset_idx_out", 32'h0});
        e = sb.pop_front(); n_cmp++;
        if (data_display !== e.val) begin
            n_err++; $display("FAIL %s: got %h want %h", e.name, data_display, e.val);
        end
        e = sb.pop_front(); n_cmp++;
        if (32'(idx_out) !== e.val) begin
            n_err++; $display("FAIL %s: got %h want %h", e.name, idx_out, e.val);
        end
        rst = 1'b0;
        tick(30);
        n_cmp++;
        if (reg_addr !== 5'd0 || mem_addr !== 8'd0) begin
            n_err++; $display("FAIL held_through_reset: reg %0d mem %0d want 0 0", reg_addr, mem_addr);
        end
        btn_inc = 1'b0; btn_dec = 1'b0;
        tick(12);
        n_cmp++;
        if (reg_addr !== 5'd0) begin
            n_err++; $display("FAIL release_after_reset: reg %0d want 0", reg_addr);
        end
    endtask

    task automatic test_debounce;
        sel = 2'b01;
        for (int len = 1; len <= 3; len++) begin
            btn_inc = 1'b1; tick(len);
            btn_inc = 1'b0; tick(8);
        end
        n_cmp++;
        if (reg_addr !== 5'd0) begin
            n_err++; $display("FAIL glitch_reject: reg %0d want 0", reg_addr);
        end
        btn_inc = 1'b1;
        for (int i = 0; i < 20 && reg_addr == 5'd0; i++) @(negedge clk);
        n_cmp++;
        if (reg_addr !== 5'd1) begin
            n_err++; $display("FAIL debounce_step: reg %0d want 1", reg_addr);
        end
        sb.push_back('{"debounce_display", regs[1]});
        tick(1);
        e = sb.pop_front(); n_cmp++;
        if (data_display !== e.val) begin
            n_err++; $display("FAIL %s: got %h want %h", e.name, data_display, e.val);
        end
        tick(5);
        btn_inc = 1'b0;
        tick(12);
        n_cmp++;
        if (reg_addr !== 5'd1 || idx_out !== 8'd1) begin
            n_err++; $display("FAIL single_step: reg %0d idx %0d want 1 1", reg_addr, idx_out);
        end
    endtask

    task automatic test_wrap;
        reg_addr_dec_from_one:
        begin
            press(1'b0, 1'b1, 6);
            press(1'b0, 1'b1, 6);
        end
        n_cmp++;
        if (reg_addr !== 5'd31) begin
            n_err++; $display("FAIL reg_wrap_down: reg %0d want 31", reg_addr);
        end
        sel = 2'b10;
        press(1'b0, 1'b1, 6);
        n_cmp++;
        if (mem_addr !== 8'd255 || idx_out !== 8'd255) begin
            n_err++; $display("FAIL mem_wrap_down: mem %0d idx %0d want 255", mem_addr, idx_out);
        end
        press(1'b1, 1'b0, 6);
        n_cmp++;
        if (mem_addr !== 8'd0) begin
            n_err++; $display("FAIL mem_wrap_up: mem %0d want 0", mem_addr);
        end
    endtask

    task automatic test_auto_repeat;
        logic [7:0] prev;
        int         t0;
        sel = 2'b10;
        sb.push_back('{"repeat_t0", 32'd0});
        sb.push_back('{"repeat_t16", 32'd16});
        sb.push_back('{"repeat_t24", 32'd24});
        sb.push_back('{"repeat_t32", 32'd32});
        prev = mem_addr;
        t0 = -1;
        btn_inc = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 40) btn_inc = 1'b0;
            if (mem_addr != prev) begin
                prev = mem_addr;
                if (t0 < 0) t0 = i;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL repeat_extra: step at +%0d want none", i - t0);
                end else begin
                    e = sb.pop_front();
                    if (32'(i - t0) !== e.val) begin
                        n_err++; $display("FAIL %s: got +%0d want +%0d", e.name, i - t0, e.val);
                    end
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL repeat_missing: %0d steps missing want 0", sb.size());
        end
        sb.delete();
        tick(4);
        n_cmp++;
        if (mem_addr !== 8'd4) begin
            n_err++; $display("FAIL repeat_count: mem %0d want 4", mem_addr);
        end
    endtask

    task automatic test_mem_latency;
        sel = 2'b10;
        press(1'b0, 1'b1, 6);
        sb.push_back('{"mem3_display", 32'hDEADBEEF});
        e = sb.pop_front(); n_cmp++;
        if (mem_addr !== 8'd3 || data_display !== e.val) begin
            n_err++; $display("FAIL %s: mem %0d got %h want 3 %h", e.name, mem_addr, data_display, e.val);
        end
        btn_inc = 1'b1;
        for (int i = 0; i < 20 && mem_addr == 8'd3; i++) @(negedge clk);
        n_cmp++;
        if (mem_addr !== 8'd4) begin
            n_err++; $display("FAIL mem_step: mem %0d want 4", mem_addr);
        end
        sb.push_back('{"stale_c0", 32'hDEADBEEF});
        sb.push_back('{"stale_c1", 32'hDEADBEEF});
        sb.push_back('{"stale_c2", 32'h12345678});
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front(); n_cmp++;
            if (data_display !== e.val) begin
                n_err++; $display("FAIL %s: got %h want %h", e.name, data_display, e.val);
            end
            @(negedge clk);
        end
        btn_inc = 1'b0;
        tick(12);
    endtask

    task automatic test_cancel_isolation;
        sel = 2'b01;
        press(1'b1, 1'b1, 6);
        sel = 2'b10;
        press(1'b1, 1'b1, 6);
        n_cmp++;
        if (reg_addr !== 5'd31 || mem_addr !== 8'd4) begin
            n_err++; $display("FAIL cancel: reg %0d mem %0d want 31 4", reg_addr, mem_addr);
        end
        sel = 2'b00;
        press(1'b1, 1'b0, 6);
        sel = 2'b11;
        press(1'b0, 1'b1, 6);
        n_cmp++;
        if (reg_addr !== 5'd31 || mem_addr !== 8'd4 || idx_out !== 8'd0) begin
            n_err++;
            $display("FAIL mode_isolation: reg %0d mem %0d idx %0d want 31 4 0",
                     reg_addr, mem_addr, idx_out);
        end
    endtask

    task automatic test_live_update;
        logic [31:0] pcs [4];
        pcs[0] = 32'h0000_0100; pcs[1] = 32'h0000_0104;
        pcs[2] = 32'hFFFF_FFFC; pcs[3] = 32'h8000_0000;
        sel = 2'b11;
        status_in = 32'hA5A5A5A5;
        sb.push_back('{"status_display", 32'hA5A5A5A5});
        tick(1);
        e = sb.pop_front(); n_cmp++;
        if (data_display !== e.val) begin
            n_err++; $display("FAIL %s: got %h want %h", e.name, data_display, e.val);
        end
        sel = 2'b00;
        for (int k = 0; k < 4; k++) begin
            pc_in = pcs[k];
            sb.push_back('{"pc_live", pcs[k]});
            tick(1);
            e = sb.pop_front(); n_cmp++;
            if (data_display !== e.val) begin
                n_err++; $display("FAIL %s: got %h want %h", e.name, data_display, e.val);
            end
        end
        sel = 2'b01;
        regs[31] = 32'h0BAD_F00D;
        sb.push_back('{"reg_live", 32'h0BAD_F00D});
        tick(1);
        e = sb.pop_front(); n_cmp++;
        if (data_display !== e.val) begin
            n_err++; $display("FAIL %s: got %h want %h", e.name, data_display, e.val);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hC0DE_0000 | 32'(i);
        for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | 32'(i * 3);
        mem[3] = 32'hDEADBEEF;
        mem[4] = 32'h12345678;
        pc_in = 32'h0; status_in = 32'h0;
        test_reset();
        test_debounce();
        test_wrap();
        test_auto_repeat();
        test_mem_latency();
        test_cancel_isolation();
        test_live_update();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
